// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone constants, arbiter state encoding and clog2
package wb_pkg;

    // Classic (non-burst) cycle type identifier
    localparam logic [2:0] CTI_CLASSIC = 3'b000;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Byte-select width for a given data width
    function automatic int sel_width(input int dat_w);
        return dat_w / 8;
    endfunction

    // Ceiling log2, usable in parameter expressions
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, one-hot grant to the first requester after last_i
module rr_pick
    import wb_pkg::*;
#(
    parameter int N = 4,
    localparam int LW = clog2(N)
)(
    input  logic [N-1:0]  req_i,
    input  logic [LW-1:0] last_i,
    output logic [N-1:0]  gnt_o
);

    localparam logic [N-1:0] ONE = N'(1);

    // Scan from the farthest slot back to the nearest so the nearest requester wins
    always_comb begin
        gnt_o = '0;
        for (int i = N; i >= 1; i--) begin
            if (|(req_i & (ONE << ((int'(last_i) + i) % N))))
                gnt_o = ONE << ((int'(last_i) + i) % N);
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone arbiter, holds grant for a whole CYC, with strobe watchdog
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_M   = 4,
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = 255,
    localparam int SEL_W  = sel_width(DAT_W),
    localparam int OW     = clog2(NUM_M),
    localparam int TW     = (TIMEOUT == 0) ? 1 : clog2(TIMEOUT + 1)
)(
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [NUM_M-1:0]       m_cyc_i,
    input  logic [NUM_M-1:0]       m_stb_i,
    input  logic [NUM_M-1:0]       m_we_i,
    input  logic [NUM_M*ADR_W-1:0] m_adr_i,
    input  logic [NUM_M*DAT_W-1:0] m_dat_i,
    input  logic [NUM_M*SEL_W-1:0] m_sel_i,
    output logic [DAT_W-1:0]       m_dat_o,
    output logic [NUM_M-1:0]       m_ack_o,
    output logic [NUM_M-1:0]       m_err_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [ADR_W-1:0]       s_adr_o,
    output logic [DAT_W-1:0]       s_dat_o,
    output logic [SEL_W-1:0]       s_sel_o,
    input  logic [DAT_W-1:0]       s_dat_i,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,
    output logic [NUM_M-1:0]       grant_o,
    output logic                   busy_o
);

    logic [0:0]       state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d, pick;
    logic [OW-1:0]    last_q, last_d, own;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic             busy, own_cyc, own_stb, to_hit;

    rr_pick #(.N(NUM_M)) u_pick (
        .req_i  (m_cyc_i),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    // Binary index of the one-hot owner
    always_comb begin
        own = '0;
        for (int i = 0; i < NUM_M; i++) if (grant_q[i]) own = OW'(i);
    end

    assign busy    = state_q == ST_BUSY;
    assign own_cyc = busy & m_cyc_i[own];
    assign own_stb = own_cyc & m_stb_i[own];
    assign to_hit  = (TIMEOUT != 0) && own_stb && (cnt_q == TW'(TIMEOUT));

    assign s_cyc_o = own_cyc;
    assign s_stb_o = own_stb & ~to_hit;
    assign s_we_o  = own_cyc & m_we_i[own];
    assign s_adr_o = own_cyc ? m_adr_i[int'(own)*ADR_W +: ADR_W] : '0;
    assign s_dat_o = own_cyc ? m_dat_i[int'(own)*DAT_W +: DAT_W] : '0;
    assign s_sel_o = own_cyc ? m_sel_i[int'(own)*SEL_W +: SEL_W] : '0;

    // ERR (slave or watchdog) always beats ACK
    assign m_dat_o = s_dat_i;
    assign m_ack_o = grant_q & {NUM_M{own_stb & s_ack_i & ~s_err_i & ~to_hit}};
    assign m_err_o = grant_q & {NUM_M{s_err_i | to_hit}};
    assign grant_o = grant_q;
    assign busy_o  = busy;

    // Claim on any request while idle; release once the owner drops CYC
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (!busy && |m_cyc_i) begin
            state_d = ST_BUSY;
            grant_d = pick;
        end else if (busy && !m_cyc_i[own]) begin
            state_d = ST_IDLE;
            grant_d = '0;
            last_d  = own;
        end
    end

    // Watchdog counts unanswered strobe cycles, saturating at TIMEOUT
    always_comb cnt_d = (TIMEOUT == 0 || !s_stb_o || s_ack_i || s_err_i) ? '0 :
                        (cnt_q == TW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;

    // Owner, last owner and watchdog registers; reset drops any cycle at once
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= OW'(NUM_M - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: random masters and slave against a transaction-level arbitration model
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
    logic [N*AW-1:0] m_adr = '0;
    logic [N*DW-1:0] m_dat = '0;
    logic [N*SW-1:0] m_sel = '0;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, grant_o;
    logic            s_cyc_o, s_stb_o, s_we_o, busy_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [DW-1:0]   s_dat_i = '0;
    logic            s_ack_i = 1'b0, s_err_i = 1'b0;

    wb_rr_arbiter #(.NUM_M(N), .ADR_W(AW), .DAT_W(DW), .TIMEOUT(TO)) dut (
        .sys_clk (sys_clk), .sys_rst (sys_rst),
        .m_cyc_i (m_cyc),   .m_stb_i (m_stb),   .m_we_i (m_we),
        .m_adr_i (m_adr),   .m_dat_i (m_dat),   .m_sel_i (m_sel),
        .m_dat_o (m_dat_o), .m_ack_o (m_ack_o), .m_err_o (m_err_o),
        .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_we_o (s_we_o),
        .s_adr_o (s_adr_o), .s_dat_o (s_dat_o), .s_sel_o (s_sel_o),
        .s_dat_i (s_dat_i), .s_ack_i (s_ack_i), .s_err_i (s_err_i),
        .grant_o (grant_o), .busy_o  (busy_o)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] dat;
    } resp_t;

    int errors = 0, checks = 0;
    resp_t q[$];
    resp_t r;
    bit mon_en = 0, gen_en = 0;

    // Reference model: bus owner, last owner and unanswered-strobe count
    int mbusy = 0, mown = 0, mlast = N - 1, mt = 0;
    logic [N-1:0] exp_grant = '0;
    logic exp_cyc = 0, exp_stb = 0, to_exp;

    int beats[N], wait_c[N];
    int sl_wait, sl_lat, sl_mode;
    logic [N-1:0] smp_resp;
    logic smp_st;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave behaviour per beat: 0 ack, 1 err, 2 ack+err, 3 never answer
    task automatic new_slave();
        int x;
        x = $urandom_range(0, 9);
        sl_wait = 0;
        sl_lat  = $urandom_range(0, 2);
        sl_mode = x < 6 ? 0 : x < 7 ? 1 : x < 8 ? 2 : 3;
    endtask

    task automatic new_beat(input int k);
        m_stb[k]            = 1'b1;
        m_we[k]             = 1'($urandom);
        m_adr[k*AW +: AW]   = $urandom;
        m_dat[k*DW +: DW]   = $urandom;
        m_sel[k*SW +: SW]   = SW'($urandom);
    endtask

    task automatic step();
        @(negedge sys_clk);
        smp_resp = m_ack_o | m_err_o;
        smp_st   = s_cyc_o & s_stb_o;
        @(posedge sys_clk);
        mt = (exp_stb && !s_ack_i && !s_err_i) ? mt + 1 : 0;
        if (mbusy == 0 && m_cyc != 0) begin
            for (int i = 1; i <= N; i++) begin
                if (m_cyc[(mlast + i) % N]) begin
                    mown = (mlast + i) % N;
                    break;
                end
            end
            mbusy = 1;
        end else if (mbusy != 0 && !m_cyc[mown]) begin
            mlast = mown;
            mbusy = 0;
        end
        #1;
        if (s_ack_i || s_err_i) begin
            s_ack_i = 1'b0;
            s_err_i = 1'b0;
            new_slave();
        end else if (!smp_st) begin
            new_slave();
        end else if (sl_mode != 3 && sl_wait >= sl_lat) begin
            s_ack_i = sl_mode != 1;
            s_err_i = sl_mode != 0;
            s_dat_i = $urandom;
        end else begin
            sl_wait++;
        end
        for (int k = 0; k < N; k++) begin
            if (beats[k] != 0) begin
                wait_c[k]++;
                if (smp_resp[k]) begin
                    beats[k]--;
                    wait_c[k] = 0;
                    if (beats[k] == 0) begin
                        m_cyc[k] = 1'b0;
                        m_stb[k] = 1'b0;
                    end else new_beat(k);
                end else if (wait_c[k] > 400) begin
                    chk("master_wait_bound", 32'(k), 32'hFFFF_FFFF);
                    beats[k] = 0;
                    m_cyc[k] = 1'b0;
                    m_stb[k] = 1'b0;
                end
            end else if (gen_en && $urandom_range(0, 3) == 0) begin
                beats[k]  = $urandom_range(1, 4);
                wait_c[k] = 0;
                m_cyc[k]  = 1'b1;
                new_beat(k);
            end
        end
        exp_grant = mbusy != 0 ? (4'b0001 << mown) : 4'b0000;
        exp_cyc   = mbusy != 0 && m_cyc[mown];
        to_exp    = exp_cyc && m_stb[mown] && mt == TO;
        exp_stb   = exp_cyc && m_stb[mown] && !to_exp;
        if (to_exp) q.push_back('{mown, 1'b1, s_dat_i});
        else if (exp_stb && (s_ack_i || s_err_i)) q.push_back('{mown, s_err_i, s_dat_i});
    endtask

    // Monitor: bus-side mux against the model, responses against the scoreboard
    always @(negedge sys_clk) begin
        if (mon_en) begin
            chk("grant", grant_o, exp_grant);
            chk("busy", busy_o, mbusy);
            chk("s_cyc", s_cyc_o, exp_cyc);
            chk("s_stb", s_stb_o, exp_stb);
            if (exp_cyc) begin
                chk("s_adr", s_adr_o, m_adr[mown*AW +: AW]);
                chk("s_dat", s_dat_o, m_dat[mown*DW +: DW]);
                chk("s_sel", s_sel_o, m_sel[mown*SW +: SW]);
                chk("s_we", s_we_o, m_we[mown]);
            end
            if ((m_ack_o | m_err_o) != 0 || q.size() != 0) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", m_ack_o | m_err_o, 0);
                end else begin
                    r = q.pop_front();
                    chk("m_ack", m_ack_o, r.err ? 4'b0000 : 4'b0001 << r.idx);
                    chk("m_err", m_err_o, r.err ? 4'b0001 << r.idx : 4'b0000);
                    chk("m_dat", m_dat_o, r.dat);
                end
            end
        end
    end

    task automatic reset_model();
        mbusy = 0; mown = 0; mlast = N - 1; mt = 0;
        exp_grant = '0; exp_cyc = 0; exp_stb = 0;
        s_ack_i = 1'b0; s_err_i = 1'b0;
        q.delete();
        new_slave();
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            beats[k] = 0;
            wait_c[k] = 0;
        end
        reset_model();
        mon_en = 1;
        repeat (3) @(posedge sys_clk);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        gen_en = 1;
        repeat (1500) step();
        for (int i = 0; i < 200 && !exp_cyc; i++) step();
        chk("busy_before_reset", exp_cyc, 1);
        mon_en = 0;
        #2 sys_rst = 1'b1;
        #1;
        chk("rst_s_cyc", s_cyc_o, 0);
        chk("rst_s_stb", s_stb_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_resp", m_ack_o | m_err_o, 0);
        repeat (2) @(posedge sys_clk);
        reset_model();
        for (int k = 0; k < N; k++) begin
            beats[k] = 1;
            wait_c[k] = 0;
            m_cyc[k] = 1'b1;
            new_beat(k);
        end
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        mon_en = 1;
        step();
        chk("post_reset_owner", grant_o, 4'b0001);
        repeat (800) step();
        gen_en = 0;
        repeat (600) step();
        for (int k = 0; k < N; k++) chk("drained", beats[k], 0);
        chk("scoreboard_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
